map_register_bank: RTL and testbench
====================================

Name: map_register_bank

Overview:
- Parametrised ROWS x COLS game-map storage register for the board datapath.
- Generalises the fixed 5x7 overwrite-only map saver with:
  - configurable dimensions;
  - runtime selection between overwrite and OR-accumulate;
  - an overlap (collision) check that rejects conflicting placements;
  - button synchronisation and edge detection;
  - a commit counter.
- Sits between the placement/shot matrix generators and the display/compare logic.

Parameters:
- ROWS, 7, number of matrix rows.
- COLS, 5, number of matrix columns (column 0 = column A).
- CNT_W, 4, width of the commit counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- botao  in  1  raw confirm push-button; asynchronous to clk.
- arm  in  1  game-state enable; a press is accepted only if arm=1 when the press is detected.
- mode  in  1  0 = overwrite, 1 = accumulate (OR) with collision check.
- clear  in  1  level; wipes the stored map while idle.
- map_in  in  ROWS*COLS  candidate matrix; bit r*COLS+c = row r, column c.
- map_out  out  ROWS*COLS  stored matrix, same bit mapping.
- collision  out  1  sticky flag: the last accumulate attempt overlapped the stored map.
- commit_pulse  out  1  one-cycle strobe when the stored map is written.
- busy  out  1  high whenever the FSM is not in IDLE.
- commit_count  out  CNT_W  number of successful commits; saturates at all-ones.

Behaviour:
- Reset (reset=0 at an edge):
  - map_out=0, collision=0, commit_pulse=0, commit_count=0, busy=0.
  - FSM=IDLE; synchroniser stages=0; snapshot=0.
  - Reset takes effect from any state, including mid-commit.
- Input synchroniser: botao passes through sync1 -> sync2 -> sync3.
  - btn_rise = sync2 & ~sync3 (combinational).
  - btn_rise goes high after the 2nd edge that samples botao=1 and stays high for exactly one cycle.
- FSM states: IDLE, CAPTURE, CHECK, COMMIT, REJECT, WAIT_RELEASE.
- IDLE:
  - If clear=1: map_out<=0, collision<=0, commit_count<=0; stay in IDLE. Any simultaneous btn_rise is discarded.
  - Else if btn_rise and arm=1: snapshot<=map_in, mode_r<=mode, go to CAPTURE.
  - Else if btn_rise and arm=0: press is ignored; stay in IDLE.
- CAPTURE:
  - overlap_r <= mode_r & |(snapshot & map_out).
  - Go to CHECK.
- CHECK:
  - If overlap_r=0: perform the write, then go to COMMIT.
    - Write is map_out <= snapshot when mode_r=0, or map_out <= map_out | snapshot when mode_r=1.
    - collision<=0 on the same edge.
    - commit_count += 1, saturating at 2^CNT_W-1.
  - Else: collision<=1, map_out unchanged, go to REJECT.
- COMMIT: commit_pulse=1 in this state only (Moore output); go to WAIT_RELEASE.
- REJECT: one cycle, no outputs change; go to WAIT_RELEASE.
- WAIT_RELEASE: stay while sync2=1; go to IDLE when sync2=0. A held button therefore commits exactly once.
- Latency: map_out updates at the 5th rising edge after the first edge that samples botao=1. commit_pulse is high for the following cycle.
- Inputs sampled after the press:
  - map_in and mode changing after CAPTURE entry have no effect on the pending operation.
  - clear and arm are ignored outside IDLE.
- Accumulating an all-zero snapshot: no overlap; commits and increments the count.
- Overwrite mode never sets collision, and a successful commit clears a previous collision.

Test Plan:
- Reset, then overwrite mode, arm=1, map_in=35'h0000001F, press botao 3 cycles -> 5th edge: map_out=35'h0000001F; commit_pulse high 1 cycle; commit_count=1; busy returns to 0 after release.
- Accumulate mode, stored 35'h0000001F, map_in=35'h00000060 -> map_out=35'h0000007F, collision=0, count=2.
- Accumulate mode, stored 35'h0000007F, map_in=35'h00000041 -> map_out unchanged, collision=1, no commit_pulse, count unchanged. Then overwrite press with 35'h1 -> map_out=35'h1, collision=0.
- Button held 50 cycles -> exactly one commit_pulse; a press with arm=0 -> no state change, busy stays 0.
- clear=1 asserted while btn_rise is high in IDLE -> map_out=0, count=0, press dropped. Sixteen commits with CNT_W=4 -> count saturates at 15.
- reset driven low during CHECK -> next edge: all outputs 0, FSM=IDLE; the pending write never occurs.

Source files
------------

// File: rtl/map_register_bank.sv
// ---------------------------------------------------------------------------
// map_register_bank
//
// Stores the ROWS x COLS game map that sits between the placement/shot matrix
// generators and the display/compare logic. A confirm press on the raw
// push-button either overwrites the stored map or ORs a new piece into it.
// In accumulate mode, a piece that overlaps the stored map is rejected and
// the sticky collision flag is set.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   botao         raw confirm push-button (asynchronous to clk)
//   arm           game-state enable, sampled when the press is detected
//   mode          0 = overwrite, 1 = OR-accumulate with collision check
//   clear         level; wipes map, collision and counter while idle
//   map_in        candidate matrix, bit r*COLS+c = row r, column c
//   map_out       stored matrix, same bit mapping
//   collision     sticky: last accumulate attempt overlapped the stored map
//   commit_pulse  one-cycle strobe in the cycle after the map is written
//   busy          high whenever the controller is not idle
//   commit_count  successful commits, saturating at all-ones
// ---------------------------------------------------------------------------
module map_register_bank #(
    parameter int ROWS  = 7,
    parameter int COLS  = 5,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   botao,
    input  logic                   arm,
    input  logic                   mode,
    input  logic                   clear,
    input  logic [ROWS*COLS-1:0]   map_in,
    output logic [ROWS*COLS-1:0]   map_out,
    output logic                   collision,
    output logic                   commit_pulse,
    output logic                   busy,
    output logic [CNT_W-1:0]       commit_count
);

    localparam int N = ROWS * COLS;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CHECK,
        COMMIT,
        REJECT,
        WAIT_RELEASE
    } state_t;

    state_t         state;
    logic           sync1;
    logic           sync2;
    logic           sync3;
    logic           btn_rise;
    logic [N-1:0]   snapshot;
    logic           mode_r;
    logic           overlap_r;

    // Two flops bring the button into the clock domain; the third is only
    // used as the "previous value" for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= botao;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign btn_rise = sync2 & ~sync3;

    // Controller. The candidate map and mode are frozen into snapshot/mode_r
    // when the press is accepted, so later changes on map_in or mode cannot
    // disturb an operation already in flight. busy and commit_pulse are kept
    // as registers that track the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            map_out      <= '0;
            collision    <= 1'b0;
            commit_pulse <= 1'b0;
            busy         <= 1'b0;
            commit_count <= '0;
            snapshot     <= '0;
            mode_r       <= 1'b0;
            overlap_r    <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    // clear wins over a press arriving on the same edge
                    if (clear) begin
                        map_out      <= '0;
                        collision    <= 1'b0;
                        commit_count <= '0;
                    end else if (btn_rise && arm) begin
                        snapshot <= map_in;
                        mode_r   <= mode;
                        busy     <= 1'b1;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    overlap_r <= mode_r & (|(snapshot & map_out));
                    state     <= CHECK;
                end
                CHECK: begin
                    if (!overlap_r) begin
                        map_out      <= mode_r ? (map_out | snapshot) : snapshot;
                        collision    <= 1'b0;
                        commit_pulse <= 1'b1;
                        if (commit_count != {CNT_W{1'b1}})
                            commit_count <= commit_count + CNT_W'(1);
                        state <= COMMIT;
                    end else begin
                        collision <= 1'b1;
                        state     <= REJECT;
                    end
                end
                COMMIT: begin
                    state <= WAIT_RELEASE;
                end
                REJECT: begin
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // a held button must not start a second operation
                    if (!sync2) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_register_bank.sv
// ---------------------------------------------------------------------------
// tb_map_register_bank
//
// Drives map_register_bank with directed scenarios followed by randomized
// presses, and compares every cycle against a behavioural model that tracks
// the operation by how many edges have elapsed since a press was accepted.
// ---------------------------------------------------------------------------
module tb_map_register_bank;

    localparam int ROWS  = 7;
    localparam int COLS  = 5;
    localparam int CNT_W = 4;
    localparam int N     = ROWS * COLS;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             botao;
    logic             arm;
    logic             mode;
    logic             clear;
    logic [N-1:0]     map_in;
    logic [N-1:0]     map_out;
    logic             collision;
    logic             commit_pulse;
    logic             busy;
    logic [CNT_W-1:0] commit_count;

    int checks = 0;
    int passes = 0;

    map_register_bank #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .botao        (botao),
        .arm          (arm),
        .mode         (mode),
        .clear        (clear),
        .map_in       (map_in),
        .map_out      (map_out),
        .collision    (collision),
        .commit_pulse (commit_pulse),
        .busy         (busy),
        .commit_count (commit_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model. phase counts edges since a press was accepted:
    // 0 idle, 1 snapshot taken, 2 decision made, 3 strobe cycle,
    // 4 waiting for the button to be released.
    bit           model_valid = 0;
    int           phase = 0;
    bit           m_did_commit = 0;
    logic [N-1:0] m_map = '0;
    logic [N-1:0] m_snap = '0;
    bit           m_mode = 0;
    bit           m_col = 0;
    int           m_cnt = 0;
    bit           seen [3];

    always @(posedge clk) begin
        bit level_two_ago;
        bit rise;
        if (!reset) begin
            model_valid  = 1;
            phase        = 0;
            m_did_commit = 0;
            m_map        = '0;
            m_snap       = '0;
            m_mode       = 0;
            m_col        = 0;
            m_cnt        = 0;
            seen         = '{0, 0, 0};
        end else begin
            // seen[k] is the button level captured k+1 edges ago
            level_two_ago = seen[1];
            rise          = seen[1] && !seen[2];
            case (phase)
                0: begin
                    if (clear) begin
                        m_map = '0;
                        m_col = 0;
                        m_cnt = 0;
                    end else if (rise && arm) begin
                        m_snap = map_in;
                        m_mode = mode;
                        phase  = 1;
                    end
                end
                1: phase = 2;
                2: begin
                    if (m_mode && ((m_snap & m_map) != '0)) begin
                        m_col        = 1;
                        m_did_commit = 0;
                    end else begin
                        m_map        = m_mode ? (m_map | m_snap) : m_snap;
                        m_col        = 0;
                        m_cnt        = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                        m_did_commit = 1;
                    end
                    phase = 3;
                end
                3: phase = 4;
                default: if (!level_two_ago) phase = 0;
            endcase
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = botao;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("cycle",
                64'({map_out, collision, commit_pulse, busy, commit_count}),
                64'({m_map, m_col, (phase == 3) && m_did_commit, phase != 0,
                     CNT_W'(m_cnt)}));
        end
    end

    function automatic logic [N-1:0] sparseMap();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 7) == 0);
        return m;
    endfunction

    // One press: hold botao for 'hold' sampled edges, release, and wait for
    // the model to go idle. With scramble set, the other inputs are
    // randomized every cycle to show that only the snapshot matters.
    task automatic applyStimulus(input logic [N-1:0] m, input bit md,
                                 input bit a, input int hold, input bit scramble,
                                 output int pulses, output int busy_seen);
        bit done;
        pulses    = 0;
        busy_seen = 0;
        @(negedge clk);
        map_in = m;
        mode   = md;
        arm    = a;
        botao  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (commit_pulse) pulses++;
            if (busy) busy_seen = 1;
            if (scramble && phase != 0) begin
                map_in = sparseMap();
                mode   = 1'($urandom);
                arm    = 1'($urandom);
                clear  = ($urandom_range(0, 3) == 0);
            end
        end
        botao = 1'b0;
        done  = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (commit_pulse) pulses++;
            if (busy) busy_seen = 1;
            if (scramble) begin
                map_in = sparseMap();
                mode   = 1'($urandom);
                arm    = 1'($urandom);
                clear  = ($urandom_range(0, 3) == 0);
            end
            if (i >= 4 && phase == 0) done = 1;
        end
        if (!done) checkOutput("idle_timeout", 64'(phase), 64'd0);
        clear = 1'b0;
        arm   = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int busy_seen;

        reset  = 1'b0;
        botao  = 1'b0;
        arm    = 1'b1;
        mode   = 1'b0;
        clear  = 1'b0;
        map_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_map", 64'(map_out), 64'd0);
        checkOutput("reset_flags", 64'({collision, commit_pulse, busy}), 64'd0);
        checkOutput("reset_count", 64'(commit_count), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] overwrite press with 5-edge latency");
        map_in = N'(35'h0000001F);
        mode   = 1'b0;
        botao  = 1'b1;
        repeat (3) @(negedge clk);
        botao = 1'b0;
        @(negedge clk);
        checkOutput("lat_edge4_map", 64'(map_out), 64'd0);
        @(negedge clk);
        checkOutput("lat_edge5_map", 64'(map_out), 64'h1F);
        checkOutput("lat_edge5_pulse", 64'(commit_pulse), 64'd1);
        checkOutput("lat_edge5_count", 64'(commit_count), 64'd1);
        @(negedge clk);
        checkOutput("lat_edge6_pulse", 64'(commit_pulse), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("lat_busy_back", 64'(busy), 64'd0);

        $display("[TB] accumulate without overlap");
        applyStimulus(N'(35'h60), 1'b1, 1'b1, 3, 1'b0, pulses, busy_seen);
        checkOutput("acc_map", 64'(map_out), 64'h7F);
        checkOutput("acc_col", 64'(collision), 64'd0);
        checkOutput("acc_count", 64'(commit_count), 64'd2);

        $display("[TB] accumulate with overlap");
        applyStimulus(N'(35'h41), 1'b1, 1'b1, 3, 1'b0, pulses, busy_seen);
        checkOutput("rej_map", 64'(map_out), 64'h7F);
        checkOutput("rej_col", 64'(collision), 64'd1);
        checkOutput("rej_pulses", 64'(pulses), 64'd0);
        checkOutput("rej_count", 64'(commit_count), 64'd2);
        applyStimulus(N'(35'h1), 1'b0, 1'b1, 3, 1'b0, pulses, busy_seen);
        checkOutput("ovr_map", 64'(map_out), 64'h1);
        checkOutput("ovr_col", 64'(collision), 64'd0);

        $display("[TB] held button and disarmed press");
        applyStimulus(N'(35'h3C0), 1'b0, 1'b1, 50, 1'b0, pulses, busy_seen);
        checkOutput("held_pulses", 64'(pulses), 64'd1);
        checkOutput("held_count", 64'(commit_count), 64'd4);
        applyStimulus(N'(35'h7), 1'b0, 1'b0, 3, 1'b0, pulses, busy_seen);
        checkOutput("disarm_busy", 64'(busy_seen), 64'd0);
        checkOutput("disarm_map", 64'(map_out), 64'h3C0);

        $display("[TB] clear during a detected press");
        map_in = N'(35'h5);
        botao  = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        botao = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("clr_map", 64'(map_out), 64'd0);
        checkOutput("clr_count", 64'(commit_count), 64'd0);
        checkOutput("clr_busy", 64'(busy), 64'd0);

        $display("[TB] counter saturation");
        for (int i = 0; i < 16; i++)
            applyStimulus(N'(i + 1), 1'b0, 1'b1, 2, 1'b0, pulses, busy_seen);
        checkOutput("sat_count", 64'(commit_count), 64'd15);

        $display("[TB] reset during decision");
        map_in = N'(35'h7FF);
        botao  = 1'b1;
        repeat (3) @(negedge clk);
        botao = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_map", 64'(map_out), 64'd0);
        checkOutput("rst_mid_flags", 64'({collision, commit_pulse, busy}), 64'd0);
        checkOutput("rst_mid_count", 64'(commit_count), 64'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("rst_no_write", 64'(map_out), 64'd0);

        $display("[TB] randomized presses");
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
            applyStimulus(sparseMap(), 1'($urandom), ($urandom_range(0, 4) != 0),
                          $urandom_range(1, 6), 1'b1, pulses, busy_seen);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
